// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: latch enable/stall/bubble sequencing, halt drain FSM
// and saturating stall/flush counters for the five-stage pipeline.
package pipeline_hazard_pkg;
   typedef enum logic [1:0] {
      PIPE_ENABLE = 2'd0,
      PIPE_STALL  = 2'd1,
      PIPE_NOP    = 2'd2
   } pipe_state_t;
endpackage

module pipeline_hazard_controller
   import pipeline_hazard_pkg::*;
(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        dREN_mem,
   input  logic        dWEN_mem,
   input  logic        dREN_ex,
   input  logic [4:0]  wsel_ex,
   input  logic [4:0]  rs_dec,
   input  logic [4:0]  rt_dec,
   input  logic        uses_rt_dec,
   input  logic        branch_taken_ex,
   input  logic        halt_ex,
   input  logic        halt_mw,
   output pipe_state_t fd_state,
   output pipe_state_t de_state,
   output pipe_state_t em_state,
   output pipe_state_t mw_state,
   output logic        pc_en,
   output logic        halt,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);
   typedef enum logic [1:0] {RUN, HALT_DRAIN, HALTED} fsm_t;

   fsm_t        state_q, state_d;
   logic        halt_q, halt_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;
   logic        mem_stall, load_use, flush_inc, stall_inc;

   assign mem_stall = (dREN_mem | dWEN_mem) & ~dhit;
   assign load_use  = dREN_ex & (wsel_ex != 5'd0) &
                      ((wsel_ex == rs_dec) | (uses_rt_dec & (wsel_ex == rt_dec)));
   assign flush_inc = (state_q == RUN) & ~mem_stall & ~halt_ex & branch_taken_ex;
   assign stall_inc = (state_q != HALTED) & ~pc_en;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q        <= RUN;
         halt_q         <= 1'b0;
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         halt_q         <= halt_d;
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:        state_d = (!mem_stall && halt_ex) ? HALT_DRAIN : RUN;
         HALT_DRAIN: state_d = (!mem_stall && halt_mw) ? HALTED : HALT_DRAIN;
         default:    state_d = HALTED;
      endcase
      halt_d         = (state_d == HALTED);
      stall_cycles_d = (stall_inc && stall_cycles_q != '1) ? stall_cycles_q + 32'd1 : stall_cycles_q;
      flush_count_d  = (flush_inc && flush_count_q != '1) ? flush_count_q + 32'd1 : flush_count_q;
   end

   // Priority chain: reset, halted, memory stall, halt/drain, flush, load-use, fetch miss.
   always_comb begin
      fd_state = PIPE_ENABLE;
      de_state = PIPE_ENABLE;
      em_state = PIPE_ENABLE;
      mw_state = PIPE_ENABLE;
      pc_en    = 1'b1;
      if (!nRST) begin
         fd_state = PIPE_NOP;
         de_state = PIPE_NOP;
         em_state = PIPE_NOP;
         mw_state = PIPE_NOP;
         pc_en    = 1'b0;
      end else if (state_q == HALTED || mem_stall) begin
         fd_state = PIPE_STALL;
         de_state = PIPE_STALL;
         em_state = PIPE_STALL;
         mw_state = PIPE_STALL;
         pc_en    = 1'b0;
      end else if (state_q == HALT_DRAIN || halt_ex) begin
         fd_state = PIPE_NOP;
         de_state = PIPE_NOP;
         pc_en    = 1'b0;
      end else if (branch_taken_ex) begin
         fd_state = PIPE_NOP;
         de_state = PIPE_NOP;
      end else if (load_use) begin
         fd_state = PIPE_STALL;
         de_state = PIPE_NOP;
         pc_en    = 1'b0;
      end else if (!ihit) begin
         fd_state = PIPE_NOP;
         pc_en    = 1'b0;
      end
   end

   assign halt         = halt_q;
   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
endmodule
